// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI slave.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // clk must run at least this many times faster than SCLK.
  localparam int unsigned MIN_OVERSAMPLE = 8;

  // Bit position within a word of the n-th bit on the wire.
  function automatic int unsigned shift_idx(input bit msb_first,
                                            input int unsigned width,
                                            input int unsigned n);
    return msb_first ? (width - 1 - n) : n;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with rise/fall detection
// on the synchronised value.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_ff;
  logic              q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= {STAGES{RESET_VAL}};
      q_d     <= RESET_VAL;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], din};
      q_d     <= sync_ff[STAGES-1];
    end
  end

  assign q    = sync_ff[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave, all four CPOL/CPHA modes, oversampling the bus on clk, with a
// one-word TX holding buffer and back-to-back words inside one SS_n frame.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy,
  output state_t            state
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int IW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_W - 1);
  localparam int unsigned   FIRST_IDX = shift_idx(MSB_FIRST, DATA_W, 0);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_n_s, ss_n_rise, ss_n_fall;
  logic [SYNC_STAGES-1:0] mosi_ff;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_n_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ss_n),
    .q    (ss_n_s),
    .rise (ss_n_rise),
    .fall (ss_n_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_ff <= {SYNC_STAGES{1'b1}};
    else     mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_ff[SYNC_STAGES-1];

  // Frame end is level-based on ss_n_s, so the raw level of sclk and the
  // ss_n rising edge are not needed.
  logic unused_ok;
  assign unused_ok = ^{sclk_s, ss_n_rise};

  logic cpol_q, cpha_q;
  logic lead, trail, sample_edge, drive_edge;
  logic start, stop;

  assign lead        = cpol_q ? sclk_fall : sclk_rise;
  assign trail       = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail : lead;
  assign drive_edge  = cpha_q ? lead  : trail;
  assign start       = ss_n_fall & en;
  assign stop        = ss_n_s | ~en;

  // Holding buffer handshake: tx_data is captured on any clk edge where
  // tx_valid & tx_ready; tx_ready is simply "buffer empty", so it falls the
  // cycle after a capture and rises the cycle after the shifter takes the word.
  logic              buf_full;
  logic [DATA_W-1:0] buf_data;
  logic              load_buf, take_buf;
  logic [DATA_W-1:0] next_word;

  logic [DATA_W-1:0] tx_sh, tx_shifted;
  logic [CW-1:0]     tx_cnt;
  logic [DATA_W-1:0] rx_sh, rx_next;
  logic [CW-1:0]     rx_cnt;
  logic [IW-1:0]     rx_idx;
  logic              under_pend;

  assign tx_ready  = ~buf_full;
  assign load_buf  = tx_valid & ~buf_full;
  assign next_word = buf_full ? buf_data : '0;
  assign take_buf  = (state == IDLE && start) ||
                     (state == ACTIVE && !stop && drive_edge && tx_cnt == CNT_FULL);

  assign tx_shifted = MSB_FIRST ? {tx_sh[DATA_W-2:0], 1'b0} : {1'b0, tx_sh[DATA_W-1:1]};
  assign rx_idx     = IW'(shift_idx(MSB_FIRST, DATA_W, 32'(rx_cnt)));

  always_comb begin
    rx_next         = rx_sh;
    rx_next[rx_idx] = mosi_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_sh       <= '0;
      rx_cnt      <= '0;
      tx_sh       <= '0;
      tx_cnt      <= '0;
      under_pend  <= 1'b0;
      buf_full    <= 1'b0;
      buf_data    <= '0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (load_buf) buf_data <= tx_data;
      buf_full <= load_buf | (buf_full & ~take_buf);

      case (state)
        IDLE: begin
          if (start) begin
            state       <= ACTIVE;
            cpol_q      <= cpol;
            cpha_q      <= cpha;
            busy        <= 1'b1;
            miso_oe     <= 1'b1;
            tx_sh       <= next_word;
            rx_cnt      <= '0;
            under_pend  <= 1'b0;
            tx_underrun <= ~buf_full;
            if (cpha) begin
              miso   <= 1'b0;
              tx_cnt <= '0;
            end else begin
              miso   <= next_word[FIRST_IDX];
              tx_cnt <= CW'(1);
            end
          end
        end

        ACTIVE: begin
          if (stop) begin
            state      <= IDLE;
            busy       <= 1'b0;
            miso_oe    <= 1'b0;
            miso       <= 1'b0;
            under_pend <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sh <= rx_next;
              if (rx_cnt == CNT_LAST) begin
                rx_cnt   <= '0;
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
              end else begin
                rx_cnt <= rx_cnt + 1'b1;
              end
              // A mid-frame empty reload is only reported once the master
              // actually clocks that word; a frame ending on the word boundary
              // leaves it unreported.
              if (under_pend) begin
                tx_underrun <= 1'b1;
                under_pend  <= 1'b0;
              end
            end
            if (drive_edge) begin
              if (tx_cnt == CNT_FULL) begin
                tx_sh      <= next_word;
                miso       <= next_word[FIRST_IDX];
                tx_cnt     <= CW'(1);
                under_pend <= ~buf_full;
              end else if (tx_cnt == '0) begin
                miso   <= tx_sh[FIRST_IDX];
                tx_cnt <= CW'(1);
              end else begin
                tx_sh  <= tx_shifted;
                miso   <= tx_shifted[FIRST_IDX];
                tx_cnt <= tx_cnt + 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: an SPI master model drives frames, and
// rx words and miso words are checked against expected queues.
module tb_spi_slave_param;
  import spi_pkg::*;

  localparam int DW   = 8;
  localparam int HALF = MIN_OVERSAMPLE;

  logic clk, rst, en, cpol, cpha, sclk, ss_n, mosi;
  logic [DW-1:0] tx_data;
  logic tx_valid;
  logic miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
  logic [DW-1:0] rx_data;
  state_t state;

  logic ss_n2, tx_valid2;
  logic miso2, miso_oe2, tx_ready2, rx_valid2, tx_underrun2, busy2;
  logic [DW-1:0] rx_data2;
  state_t state2;

  int n_checks = 0;
  int n_errors = 0;
  int underrun_cnt = 0;
  int oe_seen = 0;
  logic [DW-1:0] exp_rx_q[$];
  logic [DW-1:0] exp_miso_q[$];

  spi_slave_param #(.DATA_W(DW), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .cpol(cpol), .cpha(cpha),
    .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .busy(busy), .state(state)
  );

  spi_slave_param #(.DATA_W(DW), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_lsb (
    .clk(clk), .rst(rst), .en(en), .cpol(cpol), .cpha(cpha),
    .sclk(sclk), .ss_n(ss_n2), .mosi(mosi), .miso(miso2), .miso_oe(miso_oe2),
    .tx_data(tx_data), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .tx_underrun(tx_underrun2),
    .busy(busy2), .state(state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_rx_q.size() == 0) check("rx_valid unexpected", 32'(rx_valid), 32'd0);
      else                      check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
    end
    if (rx_valid2) check("lsb rx_valid unexpected", 32'(rx_valid2), 32'd0);
    if (tx_underrun) underrun_cnt++;
    if (miso_oe || busy) oe_seen++;
  end

  // drivers
  task automatic tx_load(input logic [DW-1:0] d);
    int t = 0;
    while (!tx_ready && t < 2000) begin
      tick(1);
      t++;
    end
    check("tx_ready before load", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    check("tx_ready after load", 32'(tx_ready), 32'd0);
  endtask

  task automatic frame(input logic [15:0] bits, input int nbits,
                       input bit expect_on, input bit keep_ss);
    logic [DW-1:0] got;
    got  = '0;
    sclk = cpol;
    tick(HALF);
    ss_n = 1'b0;
    tick(HALF);
    if (expect_on) begin
      check("busy in frame", 32'(busy), 32'd1);
      check("miso_oe in frame", 32'(miso_oe), 32'd1);
    end
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = bits[nbits-1-i];
        tick(HALF);
        got  = {got[DW-2:0], miso};
        sclk = ~sclk;
        tick(HALF);
        sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        mosi = bits[nbits-1-i];
        tick(HALF);
        got  = {got[DW-2:0], miso};
        sclk = ~sclk;
        tick(HALF);
      end
      if (expect_on && (i % DW) == DW - 1) begin
        if (exp_miso_q.size() == 0) check("miso word unexpected", 32'(got), 32'hFFFF_FFFF);
        else                        check("miso word", 32'(got), 32'(exp_miso_q.pop_front()));
      end
    end
    tick(HALF);
    if (!keep_ss) ss_n = 1'b1;
    tick(HALF);
  endtask

  initial begin
    int base;
    logic [1:0] m;
    rst = 1'b1; en = 1'b1; cpol = 1'b0; cpha = 1'b0;
    sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
    ss_n2 = 1'b1; tx_valid2 = 1'b0;
    tick(4);
    check("reset miso", 32'(miso), 32'd0);
    check("reset miso_oe", 32'(miso_oe), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset tx_underrun", 32'(tx_underrun), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset tx_ready", 32'(tx_ready), 32'd1);
    check("reset state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    tick(4);

    // mode 0
    base = underrun_cnt;
    tx_load(8'hA5);
    exp_miso_q.push_back(8'hA5);
    exp_rx_q.push_back(8'h3C);
    frame(16'h003C, 8, 1'b1, 1'b0);
    check("mode0 underrun", 32'(underrun_cnt - base), 32'd0);
    check("mode0 busy after", 32'(busy), 32'd0);
    check("mode0 miso_oe after", 32'(miso_oe), 32'd0);
    check("mode0 tx_ready after", 32'(tx_ready), 32'd1);

    // modes 1..3
    for (int k = 1; k < 4; k++) begin
      m = 2'(k);
      cpol = m[1];
      cpha = m[0];
      base = underrun_cnt;
      tx_load(8'h5A);
      exp_miso_q.push_back(8'h5A);
      exp_rx_q.push_back(8'hC3);
      frame(16'h00C3, 8, 1'b1, 1'b0);
      check("mode underrun", 32'(underrun_cnt - base), 32'd0);
      check("mode busy after", 32'(busy), 32'd0);
    end

    // back-to-back words in one frame
    cpol = 1'b0; cpha = 1'b0;
    base = underrun_cnt;
    tx_load(8'h11);
    exp_miso_q.push_back(8'h11);
    exp_miso_q.push_back(8'h22);
    exp_rx_q.push_back(8'h81);
    exp_rx_q.push_back(8'h42);
    fork
      frame(16'h8142, 16, 1'b1, 1'b0);
      tx_load(8'h22);
    join
    check("b2b underrun", 32'(underrun_cnt - base), 32'd0);

    // underrun
    base = underrun_cnt;
    exp_miso_q.push_back(8'h00);
    exp_rx_q.push_back(8'h99);
    frame(16'h0099, 8, 1'b1, 1'b0);
    check("underrun pulses", 32'(underrun_cnt - base), 32'd1);

    // abort after 5 bits, then a clean frame
    frame(16'h001F, 5, 1'b1, 1'b0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort miso_oe", 32'(miso_oe), 32'd0);
    check("abort miso", 32'(miso), 32'd0);
    tx_load(8'hF0);
    exp_miso_q.push_back(8'hF0);
    exp_rx_q.push_back(8'h0F);
    frame(16'h000F, 8, 1'b1, 1'b0);

    // reset mid-frame after 3 bits with a word waiting in the buffer
    tx_load(8'h77);
    frame(16'h0005, 3, 1'b1, 1'b1);
    tx_load(8'h33);
    rst = 1'b1;
    tick(2);
    check("midrst miso", 32'(miso), 32'd0);
    check("midrst miso_oe", 32'(miso_oe), 32'd0);
    check("midrst rx_data", 32'(rx_data), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst tx_ready", 32'(tx_ready), 32'd1);
    check("midrst state", 32'(state), 32'(IDLE));
    ss_n = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(HALF);
    check("post-reset busy", 32'(busy), 32'd0);

    // en=0 with an active bus
    en = 1'b0;
    base = oe_seen;
    frame(16'h00A5, 8, 1'b0, 1'b0);
    check("en0 oe/busy cycles", 32'(oe_seen - base), 32'd0);
    check("en0 tx_ready", 32'(tx_ready), 32'd1);
    en = 1'b1;
    tick(4);

    // LSB-first build drives bit 0 first
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    check("lsb tx_ready", 32'(tx_ready2), 32'd1);
    tx_data   = 8'h01;
    tx_valid2 = 1'b1;
    tick(1);
    tx_valid2 = 1'b0;
    tick(2);
    ss_n2 = 1'b0;
    tick(HALF);
    check("lsb miso_oe", 32'(miso_oe2), 32'd1);
    check("lsb first bit", 32'(miso2), 32'd1);
    ss_n2 = 1'b1;
    tick(HALF);
    check("lsb busy after", 32'(busy2), 32'd0);

    tick(20);
    check("rx queue drained", 32'(exp_rx_q.size()), 32'd0);
    check("miso queue drained", 32'(exp_miso_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #600000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
